// File: rtl/puf_eval_sequencer.sv
// Batch sequencer for the 8-bit arbiter PUF: arms, launches, settles and samples
// N_CH consecutive challenges. Optional majority voting via `PUF_MAJORITY_VOTE_EN`.
module puf_eval_sequencer #(
    parameter int unsigned N_CH       = 16,
    parameter int unsigned ARM_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned VOTES      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        seed,
    input  logic              puf_resp,
    output logic [7:0]        ch_out,
    output logic              puf_launch,
    output logic              puf_rst,
    output logic              busy,
    output logic              resp_valid,
    output logic [N_CH-1:0]   resp_word
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int unsigned MAX_CYC = (ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned VW      = $clog2(VOTES + 1);
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned V_EFF   = VOTES;
`else
    localparam int unsigned V_EFF   = 1;
`endif

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [VW-1:0]    vote_idx;
    logic [VW-1:0]    ones;
    logic [VW-1:0]    ones_total;
    logic             sync0;
    logic             sync1;
    logic             arm_done;
    logic             settle_done;
    logic             last_vote;
    logic             last_ch;
    logic             eval_bit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-evaluation decisions
    always_comb begin
        state_nxt   = state;
        arm_done    = (cnt == CNT_W'(ARM_CYC - 1));
        settle_done = (cnt == CNT_W'(SETTLE_CYC - 1));
        last_vote   = (vote_idx == VW'(V_EFF - 1));
        last_ch     = (idx == IDX_W'(N_CH - 1));
        ones_total  = ones + VW'(sync1);
        // With a single evaluation this reduces to the sampled bit itself
        eval_bit    = (ones_total > VW'(V_EFF / 2));

        case (state)
            S_IDLE:   if (start) state_nxt = S_ARM;
            S_ARM:    if (arm_done) state_nxt = S_LAUNCH;
            S_LAUNCH: if (settle_done) state_nxt = S_SAMPLE;
            S_SAMPLE: begin
                if (!last_vote || !last_ch) begin
                    state_nxt = S_ARM;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath, synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            vote_idx   <= '0;
            ones       <= '0;
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            ch_out     <= 8'h00;
            puf_launch <= 1'b0;
            puf_rst    <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_word  <= '0;
        end else begin
            sync0      <= puf_resp;
            sync1      <= sync0;
            cnt        <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            // Outputs follow the state being entered so they line up with it
            puf_launch <= (state_nxt == S_LAUNCH);
            puf_rst    <= (state_nxt != S_LAUNCH);
            busy       <= (state_nxt != S_IDLE);
            resp_valid <= (state_nxt == S_DONE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch_out    <= seed;
                        idx       <= '0;
                        vote_idx  <= '0;
                        ones      <= '0;
                        resp_word <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (last_vote) begin
                        resp_word[idx] <= eval_bit;
                        ch_out         <= ch_out + 8'd1;
                        idx            <= idx + IDX_W'(1);
                        vote_idx       <= '0;
                        ones           <= '0;
                    end else begin
                        vote_idx       <= vote_idx + VW'(1);
                        ones           <= ones_total;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
